ee354_apple_placer: RTL and testbench
=====================================

Name: ee354_apple_placer

Overview:
- Places the next apple on the 15x15 snake grid after each `New_Apple` request from the snake length/position block.
- Takes a pseudo-random start cell from a free-running LFSR. Probes cells linearly, one per clock, until it finds one not occupied by the snake.
- Drives `Apple_X`/`Apple_Y` to the length block and to the display path.
- Reports `Grid_Full` when no free cell exists; the game-control state machine treats this as the win condition.

Parameters:
- GRID_DIM, 15, cells per side.
- GRID_CELLS, 225, total cells (GRID_DIM*GRID_DIM).
- LFSR_SEED, 8'hA5, LFSR value loaded on reset; must be non-zero.
- INIT_X, 4'd11, apple X coordinate after reset.
- INIT_Y, 4'd7, apple Y coordinate after reset.

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- New_Apple  input  1  single-cycle request: the current apple was eaten.
- Cell_Snake_Vector  input  225  occupancy map; bit (X*15+Y) is 1 when the snake occupies cell (X,Y).
- Apple_X  output  4  current apple column, 0..14.
- Apple_Y  output  4  current apple row, 0..14.
- Apple_Valid  output  1  Apple_X/Y hold a placed apple.
- Busy  output  1  a search is in progress.
- Grid_Full  output  1  the last search found no free cell.

Behaviour:
- Reset (synchronous, active-high, one cycle is sufficient):
  - State = IDLE.
  - Apple_X = INIT_X, Apple_Y = INIT_Y, Apple_Valid = 1.
  - Busy = 0, Grid_Full = 0.
  - LFSR = LFSR_SEED.
- LFSR:
  - 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1.
  - Shifts every cycle when Reset = 0, including during searches.
- Candidate index:
  - cand = LFSR when LFSR < 225, else LFSR − 225. This gives range 0..224.
  - Cand X/Y come from a registered conversion: X = cand/15, Y = cand%15.
  - The conversion uses subtract-compare logic or a 225-entry constant ROM. No generic divider.
- FSM states: IDLE, PROBE, FULL.
- IDLE:
  - On New_Apple = 1: load Idx = cand and matching Px/Py, Probe_Cnt = 0. Set Apple_Valid = 0 and Busy = 1. Go to PROBE.
- PROBE (one cell per cycle):
  - Cell_Snake_Vector is sampled live each probe cycle, not latched at request.
  - If bit[Idx] = 0: Apple_X = Px, Apple_Y = Py, Apple_Valid = 1, Busy = 0. Go to IDLE.
  - Else, if Probe_Cnt = 224: Busy = 0, Grid_Full = 1. Go to FULL.
  - Else: Idx += 1 and Probe_Cnt += 1.
    - Py increments; when Py = 14, Py = 0 and Px increments.
    - When Idx = 224, Idx/Px/Py wrap to 0/0/0.
- FULL:
  - Apple_Valid = 0, Grid_Full = 1.
  - A New_Apple in FULL clears Grid_Full and restarts the search exactly as in IDLE.
- Latency:
  - New_Apple at cycle N with a free candidate → Apple_Valid = 1 with the new coordinates at N+2.
  - Each occupied cell probed adds 1 cycle.
  - Worst case, grid full: Grid_Full rises at N+226.
- New_Apple while Busy: ignored, no queuing.
- Reset mid-search: aborts the search and restores the reset values above on the next edge.
- Apple_X/Y change only on a successful placement or on reset. During a search they hold the eaten apple's coordinates, qualified by Apple_Valid = 0.
- Idx never leaves 0..224; Px/Py never exceed 14.

Decomposition:
- Shared package holds:
  - constants GRID_DIM, GRID_CELLS, IDX_W = 8, COORD_W = 4;
  - FSM state encoding (IDLE = 2'd0, PROBE = 2'd1, FULL = 2'd2);
  - the index↔(X,Y) mapping function.
- One sub-module is natural: ee354_lfsr8, with Clk, Reset, Seed parameter and 8-bit Q output. It is reusable for other randomised game features.
- Everything else (FSM, probe counter, coordinate tracker) stays in ee354_apple_placer.

Test Plan:
- Reset, Cell_Snake_Vector = 0 → Apple_X = 11, Apple_Y = 7, Apple_Valid = 1, Busy = 0, Grid_Full = 0. Then pulse New_Apple at cycle N → at N+2 Apple_Valid = 1 and (Apple_X*15 + Apple_Y) equals the reference-model candidate computed from the LFSR value at N.
- All bits 1 except bit 0 → pulse New_Apple → apple at (0,0). Busy high for exactly (225 − cand) + 1 cycles, covering the wrap from 224 to 0.
- All bits 1 except bit 224 → pulse New_Apple → apple at (14,14), Grid_Full = 0.
- All 225 bits 1 → pulse New_Apple → Grid_Full = 1 and Apple_Valid = 0 exactly 226 cycles after the request. Then clear bit 17 and pulse New_Apple → apple at (1,2) and Grid_Full = 0.
- Grid with 100 occupied cells → pulse New_Apple, pulse it again 3 cycles later while Busy → only one placement. The result cell is free, and Busy drops once.
- Reset asserted during PROBE (all ones except bit 0, Reset 10 cycles after the request) → next cycle: Apple = (11,7), Apple_Valid = 1, Busy = 0, LFSR = 8'hA5.

Source files
------------

// File: rtl/ee354_apple_placer_pkg.sv
// Shared constants, FSM encoding and index/coordinate helpers for the apple placer.
// Pure combinational helpers; no state lives here.
package ee354_apple_placer_pkg;

  localparam int GRID_DIM   = 15;
  localparam int GRID_CELLS = GRID_DIM * GRID_DIM;
  localparam int IDX_W      = 8;
  localparam int COORD_W    = 4;

  localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(GRID_CELLS - 1);
  localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(GRID_DIM - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PROBE = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // x^8 + x^6 + x^5 + x^4 + 1, shifting toward the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Folds the 0..255 LFSR range onto 0..224 with a single conditional subtract.
  function automatic logic [IDX_W-1:0] lfsr_to_cand(input logic [7:0] r);
    return (r < IDX_W'(GRID_CELLS)) ? r : r - IDX_W'(GRID_CELLS);
  endfunction

  // Index -> (X,Y) by repeated subtract-compare; X = idx/15, Y = idx%15.
  function automatic coord_t idx_to_xy(input logic [IDX_W-1:0] idx);
    coord_t           c;
    logic [IDX_W-1:0] rem;
    c.x = '0;
    rem = idx;
    for (int k = 0; k < GRID_DIM - 1; k++) begin
      if (rem >= IDX_W'(GRID_DIM)) begin
        rem = rem - IDX_W'(GRID_DIM);
        c.x = c.x + 4'd1;
      end
    end
    c.y = rem[COORD_W-1:0];
    return c;
  endfunction

endpackage

// File: rtl/ee354_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, reloaded with SEED on reset.
// Advances every cycle Reset is low; output is the registered state.
module ee354_lfsr8
  import ee354_apple_placer_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic [7:0] Q
);

  logic [7:0] q_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      q_q <= SEED;
    end else begin
      q_q <= lfsr8_next(q_q);
    end
  end

  assign Q = q_q;

endmodule

// File: rtl/ee354_apple_placer.sv
// Places the next apple on the 15x15 grid: random start cell, then linear probe one cell per clock.
// Free candidate gives Apple_Valid two cycles after New_Apple; each occupied cell adds one; New_Apple while Busy is dropped.
module ee354_apple_placer
  import ee354_apple_placer_pkg::*;
#(
  parameter logic [7:0]         LFSR_SEED = 8'hA5,
  parameter logic [COORD_W-1:0] INIT_X    = 4'd11,
  parameter logic [COORD_W-1:0] INIT_Y    = 4'd7
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  New_Apple,
  input  logic [GRID_CELLS-1:0] Cell_Snake_Vector,
  output logic [COORD_W-1:0]    Apple_X,
  output logic [COORD_W-1:0]    Apple_Y,
  output logic                  Apple_Valid,
  output logic                  Busy,
  output logic                  Grid_Full
);

  logic [7:0]       lfsr_q;
  logic [IDX_W-1:0] cand_idx_q, cand_idx_d;
  coord_t           cand_xy_q, cand_xy_d;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] px_q, px_d;
  logic [COORD_W-1:0] py_q, py_d;
  logic [COORD_W-1:0] ax_q, ax_d;
  logic [COORD_W-1:0] ay_q, ay_d;
  logic               av_q, av_d;

  ee354_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .Clk   (Clk),
    .Reset (Reset),
    .Q     (lfsr_q)
  );

  // Convert the LFSR's next value so the registered candidate always matches the current LFSR.
  always_comb begin
    cand_idx_d = lfsr_to_cand(lfsr8_next(lfsr_q));
    cand_xy_d  = idx_to_xy(cand_idx_d);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cand_idx_q <= lfsr_to_cand(LFSR_SEED);
      cand_xy_q  <= idx_to_xy(lfsr_to_cand(LFSR_SEED));
    end else begin
      cand_idx_q <= cand_idx_d;
      cand_xy_q  <= cand_xy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    px_d    = px_q;
    py_d    = py_q;
    ax_d    = ax_q;
    ay_d    = ay_q;
    av_d    = av_q;

    unique case (state_q)
      IDLE, FULL: begin
        if (New_Apple) begin
          idx_d   = cand_idx_q;
          px_d    = cand_xy_q.x;
          py_d    = cand_xy_q.y;
          cnt_d   = '0;
          av_d    = 1'b0;
          state_d = PROBE;
        end
      end

      PROBE: begin
        if (!Cell_Snake_Vector[idx_q]) begin
          ax_d    = px_q;
          ay_d    = py_q;
          av_d    = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == LAST_IDX) begin
          state_d = FULL;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            px_d  = '0;
            py_d  = '0;
          end else begin
            idx_d = idx_q + 8'd1;
            if (py_q == LAST_COORD) begin
              py_d = '0;
              px_d = px_q + 4'd1;
            end else begin
              py_d = py_q + 4'd1;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      ax_q    <= INIT_X;
      ay_q    <= INIT_Y;
      av_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      av_q    <= av_d;
    end
  end

  assign Apple_X     = ax_q;
  assign Apple_Y     = ay_q;
  assign Apple_Valid = av_q;
  assign Busy        = (state_q == PROBE);
  assign Grid_Full   = (state_q == FULL);

endmodule

// File: tb/tb_ee354_apple_placer.sv
// Randomised scoreboard bench for ee354_apple_placer against a linear-scan reference model.
module tb_ee354_apple_placer;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         New_Apple = 1'b0;
  logic [224:0] vec = '0;
  logic [3:0]   Apple_X, Apple_Y;
  logic         Apple_Valid, Busy, Grid_Full;

  ee354_apple_placer dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .New_Apple         (New_Apple),
    .Cell_Snake_Vector (vec),
    .Apple_X           (Apple_X),
    .Apple_Y           (Apple_Y),
    .Apple_Valid       (Apple_Valid),
    .Busy              (Busy),
    .Grid_Full         (Grid_Full)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  logic [7:0] m_lfsr;
  always @(posedge Clk)
    m_lfsr <= Reset ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};

  typedef struct {
    int done;
    int dur;
    int x;
    int y;
    bit full;
    bit seed_chk;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cur_x = 11;
  int   cur_y = 7;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int cand_of(input logic [7:0] l);
    int v;
    v = int'(l);
    return (v < 225) ? v : v - 225;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference: scan from the candidate, wrapping, for the first free cell.
  task automatic issue();
    int   c;
    int   idx;
    int   p;
    exp_t e;
    c      = cand_of(m_lfsr);
    p      = 225;
    e.full = 1'b1;
    idx    = 0;
    for (int i = 0; i < 225; i++) begin
      idx = (c + i) % 225;
      if (!vec[idx]) begin
        p      = i + 1;
        e.full = 1'b0;
        break;
      end
    end
    if (!e.full) begin
      cur_x = idx / 15;
      cur_y = idx % 15;
    end
    e.x        = cur_x;
    e.y        = cur_y;
    e.dur      = p;
    e.done     = cyc + 1 + p;
    e.seed_chk = 1'b0;
    sbq.push_back(e);
    New_Apple = 1'b1;
    tick();
    New_Apple = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sbq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Monitor: compares each completed search (Busy falling) against the scoreboard.
  bit prev_busy = 1'b0;
  int rise_cyc  = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (Busy === 1'b1 && !prev_busy) rise_cyc = cyc;
    if (Busy === 1'b1) check("valid_low_while_busy", int'(Apple_Valid), 0);
    if (prev_busy && Busy !== 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: search ended at cycle %0d with none pending", cyc);
      end else begin
        e = sbq.pop_front();
        check("done_cycle", cyc, e.done);
        check("busy_duration", cyc - rise_cyc, e.dur);
        check("apple_x", int'(Apple_X), e.x);
        check("apple_y", int'(Apple_Y), e.y);
        check("apple_valid", int'(Apple_Valid), e.full ? 0 : 1);
        check("grid_full", int'(Grid_Full), e.full ? 1 : 0);
        if (e.seed_chk) check("lfsr_reseed", int'(dut.lfsr_q), 8'hA5);
      end
    end
    prev_busy = (Busy === 1'b1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   c;
    int   k;
    int   req;
    exp_t e;

    Reset = 1'b1;
    tick();
    tick();
    check("rst_apple_x", int'(Apple_X), 11);
    check("rst_apple_y", int'(Apple_Y), 7);
    check("rst_valid", int'(Apple_Valid), 1);
    check("rst_busy", int'(Busy), 0);
    check("rst_full", int'(Grid_Full), 0);
    check("rst_lfsr", int'(dut.lfsr_q), 8'hA5);
    Reset = 1'b0;
    tick();

    // Empty grid, random spacing so the start cell varies.
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 15)) tick();
      issue();
      wait_drain(300);
    end

    // Random occupancy at several densities.
    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < 225; i++) vec[i] = ($urandom_range(0, 99) < (r % 3) * 30 + 35);
      repeat ($urandom_range(0, 10)) tick();
      issue();
      wait_drain(300);
    end

    // Only (0,0) free: exercises the 224 -> 0 wrap.
    vec = '1;
    vec[0] = 1'b0;
    issue();
    wait_drain(300);

    // Only (14,14) free.
    vec = '1;
    vec[224] = 1'b0;
    repeat ($urandom_range(1, 20)) tick();
    issue();
    wait_drain(300);

    // Full grid, then a request from FULL after freeing (1,2).
    vec = '1;
    issue();
    wait_drain(300);
    check("full_held_valid", int'(Apple_Valid), 0);
    check("full_held_flag", int'(Grid_Full), 1);
    vec[17] = 1'b0;
    repeat ($urandom_range(1, 20)) tick();
    issue();
    wait_drain(300);

    // 100 occupied cells; start cell and two successors occupied so the second pulse hits Busy.
    vec = '0;
    c = cand_of(m_lfsr);
    for (int i = 0; i < 3; i++) vec[(c + i) % 225] = 1'b1;
    n = 3;
    while (n < 100) begin
      k = $urandom_range(0, 224);
      if (!vec[k]) begin
        vec[k] = 1'b1;
        n++;
      end
    end
    issue();
    tick();
    tick();
    check("busy_at_second_pulse", int'(Busy), 1);
    New_Apple = 1'b1;
    tick();
    New_Apple = 1'b0;
    wait_drain(300);
    repeat (30) tick();
    check("busy_after_double", int'(Busy), 0);

    // Reset ten cycles into a long search.
    vec = '1;
    vec[0] = 1'b0;
    n = 0;
    while (cand_of(m_lfsr) >= 200 && n < 300) begin
      tick();
      n++;
    end
    req        = cyc;
    e.done     = req + 11;
    e.dur      = 10;
    e.x        = 11;
    e.y        = 7;
    e.full     = 1'b0;
    e.seed_chk = 1'b1;
    sbq.push_back(e);
    cur_x = 11;
    cur_y = 7;
    New_Apple = 1'b1;
    tick();
    New_Apple = 1'b0;
    repeat (9) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    wait_drain(10);

    // LFSR restarted from the seed; the reference follows it.
    vec = '0;
    repeat ($urandom_range(0, 5)) tick();
    issue();
    wait_drain(300);

    repeat (5) tick();
    check("scoreboard_empty", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
